// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and FSM state type for the TDM demux path
//
// Purpose: slot geometry of the 4:1 TDM frame and the receiver state encoding.
// Ports: none (package).

package tdm_pkg;

  localparam int SLOT_W = 2;  // width of the slot index / mux select
  localparam int NSLOT  = 4;  // beats per frame

  typedef enum logic {
    HUNT = 1'b0,  // searching for a start-of-frame marker
    RECV = 1'b1   // locked, collecting slots
  } state_t;

endpackage

// File: rtl/slot_cnt_mod4.sv
// rtl/slot_cnt_mod4.sv - modulo-4 slot index counter with load-1 and clear
//
// Purpose: tracks the slot expected on the next accepted beat.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active-high (count -> 0)
//   inc    in   advance by one, wrapping 3 -> 0
//   load1  in   force count to 1 (a slot-0 beat was just taken)
//   clr    in   force count to 0
//   cnt    out  current slot index

module slot_cnt_mod4
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] cnt
);

  // clr outranks load1, which outranks inc; the FSM never asserts more than one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= SLOT_W'(1);
    end else if (inc) begin
      cnt <= cnt + SLOT_W'(1);  // natural 2-bit overflow gives the 3 -> 0 wrap
    end
  end

endmodule

// File: rtl/tdm_demux_4.sv
// rtl/tdm_demux_4.sv - 4-slot TDM demultiplexer with start-of-frame lock
//
// Purpose: rebuilds four parallel channels from a serialized beat stream
// (slot order y1,y2,y3,y4), publishing a complete frame once per frame and
// flagging/resynchronizing on framing violations.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-high
//   din          in   serialized data beat
//   din_valid    in   beat present this cycle (no backpressure)
//   sof          in   beat is slot 0; qualified by din_valid
//   y1..y4       out  recovered channels, change only with frame_valid
//   frame_valid  out  1-cycle pulse: y1..y4 hold a new complete frame
//   c            out  slot index expected on the next beat
//   locked       out  high while in RECV
//   sync_err     out  1-cycle pulse on a framing violation

module tdm_demux_4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  input  logic              sof,
  output logic [WIDTH-1:0]  y1,
  output logic [WIDTH-1:0]  y2,
  output logic [WIDTH-1:0]  y3,
  output logic [WIDTH-1:0]  y4,
  output logic              frame_valid,
  output logic [SLOT_W-1:0] c,
  output logic              locked,
  output logic              sync_err
);

  state_t state_q, state_d;

  logic cnt_inc, cnt_load1, cnt_clr;
  logic sh0_we, sh1_we, sh2_we;
  logic publish, err;

  // Slot 3 is never stored: it goes straight to y4 together with the shadows.
  logic [WIDTH-1:0] shadow0, shadow1, shadow2;

  slot_cnt_mod4 u_slot_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .cnt   (c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_inc   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_clr   = 1'b0;
    sh0_we    = 1'b0;
    sh1_we    = 1'b0;
    sh2_we    = 1'b0;
    publish   = 1'b0;
    err       = 1'b0;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          // Non-sof beats are dropped silently while hunting.
          if (sof) begin
            state_d   = RECV;
            cnt_load1 = 1'b1;
            sh0_we    = 1'b1;
          end
        end
        default: begin  // RECV
          if (sof) begin
            // sof always restarts the frame; it is only legal at slot 0.
            cnt_load1 = 1'b1;
            sh0_we    = 1'b1;
            err       = (c != '0);
          end else if (c == '0) begin
            // Slot 0 without its marker: lock is lost.
            err     = 1'b1;
            cnt_clr = 1'b1;
            state_d = HUNT;
          end else begin
            cnt_inc = 1'b1;
            case (c)
              SLOT_W'(1): sh1_we  = 1'b1;
              SLOT_W'(2): sh2_we  = 1'b1;
              default:    publish = 1'b1;  // slot NSLOT-1 completes the frame
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow0     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      y4          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= publish;
      sync_err    <= err;
      if (sh0_we) shadow0 <= din;
      if (sh1_we) shadow1 <= din;
      if (sh2_we) shadow2 <= din;
      if (publish) begin
        y1 <= shadow0;
        y2 <= shadow1;
        y3 <= shadow2;
        y4 <= din;
      end
    end
  end

  assign locked = (state_q == RECV);

endmodule

// File: tb/tb_tdm_demux_4.sv
// tb/tb_tdm_demux_4.sv - directed self-checking bench for tdm_demux_4

module tb_tdm_demux_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] din;
  logic       din_valid;
  logic       sof;
  logic [0:0] y1, y2, y3, y4;
  logic       frame_valid;
  logic [1:0] c;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int errors = 0;

  tdm_demux_4 #(.WIDTH(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .y4          (y4),
    .frame_valid (frame_valid),
    .c           (c),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat, let one rising edge sample it, return 1 time unit later.
  task automatic send(input logic v, input logic s, input logic d);
    din_valid = v;
    sof       = s;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  // Full observable state after the last edge; y packed as {y1,y2,y3,y4}.
  task automatic expect_all(input string tag, input logic [3:0] y, input logic fv,
                            input logic [1:0] cc, input logic lk, input logic se);
    check({tag, ".y"},  {y1, y2, y3, y4}, y);
    check({tag, ".fv"}, frame_valid, fv);
    check({tag, ".c"},  c, cc);
    check({tag, ".lk"}, locked, lk);
    check({tag, ".se"}, sync_err, se);
  endtask

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    sof       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_all("reset", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // HUNT ignore: valid non-sof beats produce nothing.
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b0, 1'b1);
      expect_all("hunt", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    end

    // Clean frame 0,1,0,1.
    send(1'b1, 1'b1, 1'b0); expect_all("f1b0", 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1); expect_all("f1b1", 4'b0000, 1'b0, 2'd2, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0); expect_all("f1b2", 4'b0000, 1'b0, 2'd3, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1); expect_all("f1b3", 4'b0101, 1'b1, 2'd0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0); expect_all("f1idle", 4'b0101, 1'b0, 2'd0, 1'b1, 1'b0);

    // Frame 0,0,1,0 with a gap between beats 2 and 3, then back-to-back 0,1,0,1.
    send(1'b1, 1'b1, 1'b0); expect_all("f2b0", 4'b0101, 1'b0, 2'd1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0); expect_all("f2b1", 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b1); expect_all("f2gap0", 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b1); expect_all("f2gap1", 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1); expect_all("f2b2", 4'b0101, 1'b0, 2'd3, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0); expect_all("f2b3", 4'b0010, 1'b1, 2'd0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0); expect_all("f3b0", 4'b0010, 1'b0, 2'd1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1); expect_all("f3b3", 4'b0101, 1'b1, 2'd0, 1'b1, 1'b0);

    // Early sof at c==2: error, old outputs held, new frame 0,1,1,0 completes.
    send(1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b1); expect_all("e1pre", 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0); expect_all("e1sof", 4'b0101, 1'b0, 2'd1, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b1); expect_all("e1b1", 4'b0101, 1'b0, 2'd2, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b0); expect_all("e1b3", 4'b0110, 1'b1, 2'd0, 1'b1, 1'b0);

    // sof coinciding with the 4th beat: frame discarded, restart as slot 0 (d=1).
    send(1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0); expect_all("e2pre", 4'b0110, 1'b0, 2'd3, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b1); expect_all("e2sof", 4'b0110, 1'b0, 2'd1, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b1); expect_all("e2b3", 4'b1011, 1'b1, 2'd0, 1'b1, 1'b0);

    // Missing sof at slot 0: lock lost, later non-sof beats ignored, sof relocks.
    send(1'b1, 1'b0, 1'b1); expect_all("m0", 4'b1011, 1'b0, 2'd0, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b1); expect_all("m1", 4'b1011, 1'b0, 2'd0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0); expect_all("m2", 4'b1011, 1'b0, 2'd0, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0); expect_all("mrelock", 4'b1011, 1'b0, 2'd1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1); expect_all("mb1", 4'b1011, 1'b0, 2'd2, 1'b1, 1'b0);

    // Asynchronous reset mid-frame, between clock edges.
    din_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    expect_all("arst", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Recovery after reset: clean frame 1,0,1,1.
    send(1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b1); expect_all("post", 4'b1011, 1'b1, 2'd0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0); expect_all("postidle", 4'b1011, 1'b0, 2'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
